// File: rtl/ppu_pkg.sv
// Shared types and sizing helpers for the sprite blitter.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    RMW,
    FINISH
  } ppu_state_e;

  localparam int SCREEN_RAM_OFFSET_DEF = 'h100;

  // Pixel column width for a screen that is w_bytes bytes wide.
  function automatic int x_w(input int w_bytes);
    return $clog2(8 * w_bytes);
  endfunction

  // Pixel row width for a screen that is h rows tall.
  function automatic int y_w(input int h);
    return $clog2(h);
  endfunction

endpackage

// File: rtl/ppu_row_shifter.sv
// Places one sprite row at the MSB end of a 24-bit window and shifts it right
// by the sub-byte pixel offset, splitting the result into three screen bytes.
// Narrow sprites use only bits_i[15:8].
module ppu_row_shifter (
  input  logic [15:0] bits_i,
  input  logic        wide_i,
  input  logic [2:0]  shift_i,
  output logic [7:0]  s0_o,
  output logic [7:0]  s1_o,
  output logic [7:0]  s2_o
);

  logic [23:0] row_w;

  assign row_w = {bits_i[15:8], (wide_i ? bits_i[7:0] : 8'h00), 8'h00} >> shift_i;
  assign s0_o  = row_w[23:16];
  assign s1_o  = row_w[15:8];
  assign s2_o  = row_w[7:0];

endmodule

// File: rtl/ppu_blitter.sv
// XOR sprite blitter with wrap/clip edges, per-row collision count and a
// framebuffer clear command.
//
// state  | meaning
// IDLE   | waiting for draw or clear
// CLEAR  | writing 8'h00 to one framebuffer byte per cycle
// FETCH  | reading the sprite row (1 cycle narrow, 2 cycles wide)
// RMW    | read/xor/write pipeline over the row's screen bytes
// FINISH | one-cycle done pulse, then back to IDLE
module ppu_blitter
  import ppu_pkg::*;
#(
  parameter int  SCREEN_W_BYTES    = 8,
  parameter int  SCREEN_H          = 32,
  parameter int  ADDR_W            = 12,
  parameter int  SCREEN_RAM_OFFSET = SCREEN_RAM_OFFSET_DEF,
  localparam int X_W               = x_w(SCREEN_W_BYTES),
  localparam int Y_W               = y_w(SCREEN_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              draw,
  input  logic              clear,
  input  logic              wide,
  input  logic              wrap_mode,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        sprite_height,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [4:0]        collision_rows,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_read_enable,
  input  logic [7:0]        mem_read_data,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [7:0]        mem_write_data,
  output logic              mem_write_enable
);

  localparam int CW    = $clog2(SCREEN_W_BYTES);
  localparam int CNT_W = $clog2(SCREEN_W_BYTES * SCREEN_H);
  // Wide enough for ys + row index without overflow.
  localparam int SUM_W = ((Y_W > 5) ? Y_W : 5) + 1;
  localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(SCREEN_W_BYTES * SCREEN_H - 1);
  localparam logic [ADDR_W-1:0] FB_BASE  = ADDR_W'(SCREEN_RAM_OFFSET);

  ppu_state_e state_q, state_d;

  logic              wide_q, wrap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rows_q, row_q;
  logic [Y_W-1:0]    ys_q;
  logic [2:0]        shift_q;
  logic [CW-1:0]     col0_q;
  logic              fphase_q;
  logic [1:0]        k_q;
  logic [15:0]       sprite_q;
  logic              coll_q, row_hit_q;
  logic [4:0]        crows_q;
  logic [CNT_W-1:0]  clr_q;

  logic [7:0]        s0, s1, s2, s_wr;
  logic [1:0]        nbytes;
  logic [SUM_W-1:0]  row_sum, next_sum;
  logic [Y_W-1:0]    scr_row;
  logic [CW+1:0]     rd_cfull, wr_cfull;
  logic              rd_ok, wr_ok;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              hit, row_end;

  ppu_row_shifter u_shift (
    .bits_i  (sprite_q),
    .wide_i  (wide_q),
    .shift_i (shift_q),
    .s0_o    (s0),
    .s1_o    (s1),
    .s2_o    (s2)
  );

  // Screen bytes touched per row: one per sprite byte plus a spill byte when unaligned.
  assign nbytes   = 2'd1 + {1'b0, wide_q} + {1'b0, |shift_q};
  assign row_sum  = SUM_W'(ys_q) + SUM_W'(row_q);
  assign next_sum = row_sum + SUM_W'(1);
  assign scr_row  = row_sum[Y_W-1:0];

  // Read targets byte k, write targets byte k-1 (the one read last cycle).
  assign rd_cfull = {2'b00, col0_q} + {{CW{1'b0}}, k_q};
  assign wr_cfull = {2'b00, col0_q} + {{CW{1'b0}}, k_q - 2'd1};
  assign rd_ok    = wrap_q || (rd_cfull < (CW+2)'(SCREEN_W_BYTES));
  assign wr_ok    = wrap_q || (wr_cfull < (CW+2)'(SCREEN_W_BYTES));
  assign rd_addr  = FB_BASE + ADDR_W'({scr_row, rd_cfull[CW-1:0]});
  assign wr_addr  = FB_BASE + ADDR_W'({scr_row, wr_cfull[CW-1:0]});
  assign s_wr     = (k_q == 2'd1) ? s0 : ((k_q == 2'd2) ? s1 : s2);

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);
  assign collision      = coll_q;
  assign collision_rows = crows_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and memory port drive.
  always_comb begin
    state_d           = state_q;
    mem_read_enable   = 1'b0;
    mem_read_address  = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = 8'h00;
    hit               = 1'b0;
    row_end           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
        end else if (draw) begin
          if (!wide && sprite_height == 4'd0) state_d = FINISH;
          else                                state_d = FETCH;
        end
      end
      CLEAR: begin
        mem_write_enable  = 1'b1;
        mem_write_address = FB_BASE + ADDR_W'(clr_q);
        if (clr_q == CLR_LAST) state_d = FINISH;
      end
      FETCH: begin
        mem_read_enable = 1'b1;
        if (wide_q) mem_read_address = addr_q + ADDR_W'({row_q, 1'b0}) + ADDR_W'(fphase_q);
        else        mem_read_address = addr_q + ADDR_W'(row_q);
        if (!wide_q || fphase_q) state_d = RMW;
      end
      RMW: begin
        if (k_q < nbytes && rd_ok) begin
          mem_read_enable  = 1'b1;
          mem_read_address = rd_addr;
        end
        if (k_q != 2'd0 && wr_ok) begin
          mem_write_enable  = 1'b1;
          mem_write_address = wr_addr;
          mem_write_data    = mem_read_data ^ s_wr;
          hit               = |(mem_read_data & s_wr);
        end
        if (k_q == nbytes) begin
          row_end = 1'b1;
          if ((row_q + 5'd1 == rows_q) || (!wrap_q && next_sum >= SUM_W'(SCREEN_H)))
            state_d = FINISH;
          else
            state_d = FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation parameters, sprite capture, pipeline counters and collision tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wide_q    <= 1'b0;
      wrap_q    <= 1'b0;
      addr_q    <= '0;
      rows_q    <= '0;
      row_q     <= '0;
      ys_q      <= '0;
      shift_q   <= '0;
      col0_q    <= '0;
      fphase_q  <= 1'b0;
      k_q       <= '0;
      sprite_q  <= '0;
      coll_q    <= 1'b0;
      row_hit_q <= 1'b0;
      crows_q   <= '0;
      clr_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            clr_q <= '0;
          end else if (draw) begin
            // x and y are exactly one screen wide/tall, so the mod is implicit.
            wide_q    <= wide;
            wrap_q    <= wrap_mode;
            addr_q    <= address;
            rows_q    <= (wide && sprite_height == 4'd0) ? 5'd16 : {1'b0, sprite_height};
            row_q     <= '0;
            ys_q      <= y;
            shift_q   <= x[2:0];
            col0_q    <= x[X_W-1:3];
            fphase_q  <= 1'b0;
            k_q       <= '0;
            coll_q    <= 1'b0;
            row_hit_q <= 1'b0;
            crows_q   <= '0;
          end
        end
        CLEAR: clr_q <= clr_q + CNT_W'(1);
        FETCH: begin
          if (wide_q) fphase_q <= ~fphase_q;
          if (wide_q && fphase_q) sprite_q[15:8] <= mem_read_data;
          k_q <= '0;
        end
        RMW: begin
          if (k_q == 2'd0) begin
            if (wide_q) sprite_q[7:0]  <= mem_read_data;
            else        sprite_q[15:8] <= mem_read_data;
          end
          if (hit) begin
            coll_q    <= 1'b1;
            row_hit_q <= 1'b1;
          end
          k_q <= k_q + 2'd1;
          if (row_end) begin
            row_q     <= row_q + 5'd1;
            k_q       <= '0;
            row_hit_q <= 1'b0;
            if ((row_hit_q || hit) && crows_q != 5'd31) crows_q <= crows_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_blitter.sv
// Scoreboard bench for ppu_blitter: stimulus pushes expected writes and
// completion status; a negedge monitor pops and compares them.
module tb_ppu_blitter;

  typedef struct packed {
    logic        coll;
    logic [4:0]  rows;
    logic [15:0] busy;
  } st_t;

  logic        clk;
  logic        reset_n;
  logic        draw, clear, wide, wrap_mode;
  logic [11:0] address;
  logic [3:0]  sprite_height;
  logic [5:0]  x;
  logic [4:0]  y;
  logic        busy, done, collision;
  logic [4:0]  collision_rows;
  logic [11:0] mem_read_address, mem_write_address;
  logic        mem_read_enable, mem_write_enable;
  logic [7:0]  mem_read_data, mem_write_data;

  logic [7:0]  mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_a;
  logic [7:0]  bd_d;

  int          n_pass, n_total, done_seen, busy_cnt;
  logic        sb_off;
  logic [19:0] exp_wr[$];
  st_t         exp_st[$];
  logic [19:0] e_wr;
  st_t         e_st;

  ppu_blitter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .draw              (draw),
    .clear             (clear),
    .wide              (wide),
    .wrap_mode         (wrap_mode),
    .address           (address),
    .sprite_height     (sprite_height),
    .x                 (x),
    .y                 (y),
    .busy              (busy),
    .done              (done),
    .collision         (collision),
    .collision_rows    (collision_rows),
    .mem_read_address  (mem_read_address),
    .mem_read_enable   (mem_read_enable),
    .mem_read_data     (mem_read_data),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: 1-cycle read latency, backdoor port for preload.
  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
    if (mem_read_enable) mem_read_data <= mem[mem_read_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares every write and every done pulse against the queues.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_write_enable && !sb_off) begin
        if (exp_wr.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: addr %0h data %0h with none expected",
                   mem_write_address, mem_write_data);
        end else begin
          e_wr = exp_wr.pop_front();
          check("wr_addr", 32'(mem_write_address), 32'(e_wr[19:8]));
          check("wr_data", 32'(mem_write_data), 32'(e_wr[7:0]));
        end
      end
      if (done) begin
        done_seen++;
        if (!sb_off) begin
          if (exp_st.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: busy cycles %0d with no operation expected", busy_cnt);
          end else begin
            e_st = exp_st.pop_front();
            check("collision", 32'(collision), 32'(e_st.coll));
            check("collision_rows", 32'(collision_rows), 32'(e_st.rows));
            check("busy_cycles", 32'(busy_cnt), 32'(e_st.busy));
          end
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic push_st(input logic c, input logic [4:0] r, input int b);
    exp_st.push_back({c, r, 16'(b)});
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_a  = a;
    bd_d  = d;
  endtask

  task automatic run_op(input logic is_clr, input logic [11:0] a, input logic [3:0] h,
                        input logic [5:0] xx, input logic [4:0] yy,
                        input logic wd, input logic wr);
    int d0;
    int i;
    d0 = done_seen;
    @(posedge clk); #1;
    address = a; sprite_height = h; x = xx; y = yy; wide = wd; wrap_mode = wr;
    draw = ~is_clr; clear = is_clr;
    @(posedge clk); #1;
    draw = 1'b0; clear = 1'b0;
    // Scramble the operands: the operation must use its latched copies.
    address = 12'($urandom); sprite_height = 4'($urandom); x = 6'($urandom);
    y = 5'($urandom); wide = 1'($urandom); wrap_mode = 1'($urandom);
    i = 0;
    while (done_seen == d0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    check("op_completes", 32'(done_seen != d0), 32'd1);
  endtask

  initial begin
    n_pass = 0; n_total = 0; done_seen = 0; busy_cnt = 0; sb_off = 1'b0;
    reset_n = 1'b0; draw = 1'b0; clear = 1'b0; wide = 1'b0; wrap_mode = 1'b0;
    address = '0; sprite_height = '0; x = '0; y = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;

    for (int a = 'h100; a < 'h200; a++) bd_write(12'(a), 8'h00);
    bd_write(12'h050, 8'hF0); bd_write(12'h051, 8'h90); bd_write(12'h052, 8'h90);
    bd_write(12'h053, 8'h90); bd_write(12'h054, 8'hF0);
    bd_write(12'h060, 8'hFF); bd_write(12'h061, 8'hFF);
    for (int a = 'h200; a < 'h220; a++) bd_write(12'(a), 8'hFF);
    @(negedge clk);
    bd_we = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_collision_rows", 32'(collision_rows), 32'd0);
    check("rst_read_enable", 32'(mem_read_enable), 32'd0);
    check("rst_write_enable", 32'(mem_write_enable), 32'd0);
    check("rst_read_address", 32'(mem_read_address), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Aligned narrow "0" glyph on a blank screen.
    push_wr(12'h100, 8'hF0); push_wr(12'h108, 8'h90); push_wr(12'h110, 8'h90);
    push_wr(12'h118, 8'h90); push_wr(12'h120, 8'hF0);
    push_st(1'b0, 5'd0, 16);
    run_op(1'b0, 12'h050, 4'd5, 6'd0, 5'd0, 1'b0, 1'b1);

    // Same draw again erases it: every row collides.
    push_wr(12'h100, 8'h00); push_wr(12'h108, 8'h00); push_wr(12'h110, 8'h00);
    push_wr(12'h118, 8'h00); push_wr(12'h120, 8'h00);
    push_st(1'b1, 5'd5, 16);
    run_op(1'b0, 12'h050, 4'd5, 6'd0, 5'd0, 1'b0, 1'b1);

    // Clear: 256 ascending zero writes, collision status held.
    for (int a = 'h100; a < 'h200; a++) push_wr(12'(a), 8'h00);
    push_st(1'b1, 5'd5, 257);
    run_op(1'b1, 12'h000, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0);

    // Zero-row narrow draw: no memory traffic, collision cleared.
    push_st(1'b0, 5'd0, 1);
    run_op(1'b0, 12'h050, 4'd0, 6'd5, 5'd3, 1'b0, 1'b1);

    // Unaligned: FF at x=3, y=2 -> 1F E0.
    push_wr(12'h110, 8'h1F); push_wr(12'h111, 8'hE0);
    push_st(1'b0, 5'd0, 5);
    run_op(1'b0, 12'h060, 4'd1, 6'd3, 5'd2, 1'b0, 1'b1);

    // Wrap at both edges from x=60, y=31.
    push_wr(12'h1FF, 8'h0F); push_wr(12'h1F8, 8'hF0);
    push_wr(12'h107, 8'h0F); push_wr(12'h100, 8'hF0);
    push_st(1'b0, 5'd0, 9);
    run_op(1'b0, 12'h060, 4'd2, 6'd60, 5'd31, 1'b0, 1'b1);

    // Clip: only 0x1FF touched (0F ^ 0F, collides), blit ends after row 0.
    push_wr(12'h1FF, 8'h00);
    push_st(1'b1, 5'd1, 5);
    run_op(1'b0, 12'h060, 4'd2, 6'd60, 5'd31, 1'b0, 1'b0);

    // Wide, height 0 = 16 rows of FF FF. Row 0 holds F0 00, row 2 holds 1F E0.
    for (int r = 0; r < 16; r++) begin
      push_wr(12'h100 + 12'(8 * r), (r == 0) ? 8'h0F : ((r == 2) ? 8'hE0 : 8'hFF));
      push_wr(12'h101 + 12'(8 * r), (r == 2) ? 8'h1F : 8'hFF);
    end
    push_st(1'b1, 5'd2, 81);
    run_op(1'b0, 12'h200, 4'd0, 6'd0, 5'd0, 1'b1, 1'b1);

    // Wide unaligned x=4 over 0F FF 00: sprite bytes 0F FF F0.
    push_wr(12'h100, 8'h00); push_wr(12'h101, 8'h00); push_wr(12'h102, 8'hF0);
    push_st(1'b1, 5'd1, 7);
    run_op(1'b0, 12'h200, 4'd1, 6'd4, 5'd0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a draw.
    sb_off = 1'b1;
    @(posedge clk); #1;
    address = 12'h050; sprite_height = 4'd5; x = 6'd0; y = 5'd8;
    wide = 1'b0; wrap_mode = 1'b1; draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_read_enable", 32'(mem_read_enable), 32'd0);
    check("abort_write_enable", 32'(mem_write_enable), 32'd0);
    check("abort_collision_rows", 32'(collision_rows), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sb_off = 1'b0;

    // Draw after the abort is accepted normally.
    push_wr(12'h1A0, 8'hFF);
    push_st(1'b0, 5'd0, 4);
    run_op(1'b0, 12'h060, 4'd1, 6'd0, 5'd20, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    check("writes_drained", 32'(exp_wr.size()), 32'd0);
    check("status_drained", 32'(exp_st.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppu_blitter.md
Name: ppu_blitter

Overview:
- Parametrised successor to the CHIP-8 sprite PPU. XOR-blits 8-wide (CHIP-8) or 16-wide (SCHIP) sprites into a byte-packed, row-major framebuffer.
- Adds selectable wrap or clip at the screen edges, per-row collision counting, and a hardware screen-clear command.
- Sits between the CPU core (draw/clear command, busy/done/collision) and the shared system RAM. RAM is accessed through a separate read port and write port, both with 1-cycle read latency.

Parameters:
- SCREEN_W_BYTES, 8, framebuffer width in bytes (width in pixels = 8*SCREEN_W_BYTES); power of two.
- SCREEN_H, 32, framebuffer height in rows; power of two.
- ADDR_W, 12, memory address width.
- SCREEN_RAM_OFFSET, 12'h100, framebuffer base address.
- Localparams: X_W = clog2(8*SCREEN_W_BYTES), Y_W = clog2(SCREEN_H).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- draw  in  1  start a sprite blit (sampled only in IDLE)
- clear  in  1  start a framebuffer clear (sampled only in IDLE; wins over draw)
- wide  in  1  0 = 8-pixel sprite, 1 = 16-pixel sprite (2 bytes per row)
- wrap_mode  in  1  1 = wrap at edges, 0 = clip at edges
- address  in  ADDR_W  sprite base address (I)
- sprite_height  in  4  row count; 0 with wide=1 means 16 rows
- x  in  X_W  pixel column
- y  in  Y_W  pixel row
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on completion
- collision  out  1  at least one set pixel was erased
- collision_rows  out  5  number of sprite rows containing a collision
- mem_read_address  out  ADDR_W
- mem_read_enable  out  1
- mem_read_data  in  8  valid the cycle after the address is presented
- mem_write_address  out  ADDR_W
- mem_write_data  out  8
- mem_write_enable  out  1

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - busy, done, collision, collision_rows, and all mem enables are 0.
  - A draw or clear in progress is aborted; RAM contents already written are left as they are.
- Outputs:
  - Memory port outputs are combinational from state and registers; they are 0 when the corresponding enable is low.
  - busy = (state != IDLE).
- IDLE:
  - On clear: latch byte counter = 0 and go to CLEAR.
  - Else on draw: go to FETCH. On the same edge:
    - latch xs = x mod width and ys = y mod height;
    - latch shift = xs[2:0] and col0 = xs>>3;
    - clear collision and collision_rows;
    - set rows = (wide && sprite_height==0) ? 16 : sprite_height.
  - draw or clear while busy is ignored.
- Zero-row draw: rows==0 (narrow, height 0) goes straight to FINISH. busy is high for 1 cycle, no memory access, collision=0.
- FETCH:
  - Sprite row r is at address + r (narrow) or address + 2r (high byte) and +2r+1 (low byte) (wide).
  - Takes 1 cycle (narrow) or 2 cycles (wide).
  - The fetched bits are placed at the MSB of a 24-bit row and shifted right by shift, giving bytes S0..S2.
- RMW pipeline over B screen bytes:
  - B = 1 + wide + (shift != 0).
  - Screen byte k has column c = col0 + k.
  - Cycle k reads byte k. Cycle k+1 writes byte k as rd ^ Sk and, in the same cycle, reads byte k+1.
  - Takes B+1 cycles. Write address for byte k = SCREEN_RAM_OFFSET + row*SCREEN_W_BYTES + c.
  - Collision: collision |= |(rd & Sk).
  - collision_rows is incremented once per row with any collision; it saturates at 31.
- Edge handling:
  - Wrap mode: c is taken mod SCREEN_W_BYTES, and the screen row is (ys + r) mod SCREEN_H.
  - Clip mode: bytes with c >= SCREEN_W_BYTES get no read, no write and no collision, but still consume their pipeline slot (cycle count is unchanged).
  - Clip mode: a row with ys + r >= SCREEN_H ends the blit and goes to FINISH.
- Row cycle counts (cycles per row):
  - narrow, aligned: 3
  - narrow, unaligned: 4
  - wide, aligned: 5
  - wide, unaligned: 6
- After the last row, go to FINISH.
- FINISH: done=1 for one cycle, busy still 1; next state is IDLE.
- CLEAR:
  - One write of 8'h00 per cycle, in ascending address order, over SCREEN_W_BYTES*SCREEN_H bytes; then FINISH.
  - collision and collision_rows are held at their previous values.
- Inputs other than draw/clear are sampled only at acceptance; later changes have no effect on an operation in progress.

Decomposition:
- ppu_pkg holds:
  - the state enum: IDLE, CLEAR, FETCH, RMW, FINISH;
  - the default SCREEN_RAM_OFFSET;
  - the X_W and Y_W width functions.
- Sub-module ppu_row_shifter:
  - combinational;
  - inputs: 16-bit sprite bits, wide, shift;
  - outputs: S0, S1, S2;
  - verified standalone.

Test Plan:
- Aligned narrow draw, blank screen: address=0x050 holds F0 90 90 90 F0; draw x=0, y=0, height 5 -> 0x100/0x108/0x110/0x118/0x120 = F0/90/90/90/F0. collision=0, busy for 16 cycles including FINISH, one done pulse.
- Repeat the same draw -> those five bytes become 00, collision=1, collision_rows=5.
- Unaligned draw: sprite FF, x=3, y=2, height 1 -> 0x110=1F, 0x111=E0, row takes 4 cycles.
- Edge draw: sprite FF FF, x=60, y=31.
  - wrap_mode=1 -> 0x1FF=0F, 0x1F8=F0, 0x107=0F, 0x100=F0.
  - wrap_mode=0 -> only 0x1FF=0F is written (no write to 0x1F8); FINISH after row 0.
- Wide draw: wide=1, height 0, x=0, y=0, 32 bytes of FF -> 16 rows with bytes 0,1 = FF FF; 80 busy cycles before done.
- Clear command -> 256 consecutive writes of 00 to 0x100..0x1FF. Separately, assert reset_n low mid-draw -> busy, done and enables drop immediately (asynchronously), and a subsequent draw is accepted normally.
